// File: rtl/vsc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vsc_pkg
//  Description : Shared types for the vector sequencer control unit: opcode
//                map, FSM state encoding and the packed control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package vsc_pkg;

    typedef enum logic [3:0] {
        OP_SUM   = 4'b0000,
        OP_SUMFV = 4'b0001,
        OP_SUMI  = 4'b0010,
        OP_MULFV = 4'b0011,
        OP_SUBI  = 4'b0100,
        OP_LDV   = 4'b0101,
        OP_CMPEQ = 4'b0110,
        OP_NOP   = 4'b0111,
        OP_J     = 4'b1000,
        OP_JEQ   = 4'b1001,
        OP_SETI  = 4'b1010,
        OP_SETFV = 4'b1011
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VEC  = 2'd1,
        S_MEM  = 2'd2
    } state_e;

    // Eleven datapath control bits, MSB first in this order.
    typedef struct packed {
        logic mux_pc;
        logic sca_reg_w;
        logic vec_reg_w;
        logic sca_mux_exe;
        logic sca_alu_op;
        logic vec_alu_op;
        logic w_mem;
        logic r_mem;
        logic sca_reg_wd;
        logic vec_reg_wd;
        logic vec_reg_wfp;
    } ctrl_t;

    localparam ctrl_t c_ctrl_none = '0;

endpackage : vsc_pkg
`default_nettype wire

// File: rtl/vsc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : vsc_decode
//  Description : Combinational opcode decoder producing the control bundle
//                and vector / memory / illegal classification flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsc_decode
    import vsc_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_flag_zero,
    output ctrl_t      o_ctrl,
    output logic       o_is_vec,
    output logic       o_is_mem,
    output logic       o_illegal
);

    // Opcode to control bundle; undefined opcodes decode to an all-zero bundle.
    always_comb begin
        o_ctrl    = c_ctrl_none;
        o_is_vec  = 1'b0;
        o_is_mem  = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_SUM: begin
                o_ctrl.sca_reg_w  = 1'b1;
                o_ctrl.sca_reg_wd = 1'b1;
            end
            OP_SUMI: begin
                o_ctrl.sca_reg_w   = 1'b1;
                o_ctrl.sca_mux_exe = 1'b1;
            end
            OP_SUBI: begin
                o_ctrl.sca_reg_w   = 1'b1;
                o_ctrl.sca_mux_exe = 1'b1;
                o_ctrl.sca_alu_op  = 1'b1;
            end
            OP_SETI:  o_ctrl.sca_reg_w = 1'b1;
            OP_CMPEQ: ;
            OP_NOP:   ;
            OP_J:     o_ctrl.mux_pc = 1'b1;
            // Branch decision uses the registered compare flag only.
            OP_JEQ:   o_ctrl.mux_pc = i_flag_zero;
            OP_SUMFV: begin
                o_ctrl.vec_alu_op = 1'b1;
                o_ctrl.w_mem      = 1'b1;
                o_is_mem          = 1'b1;
            end
            OP_MULFV: begin
                o_ctrl.vec_reg_w  = 1'b1;
                o_ctrl.vec_alu_op = 1'b1;
                o_ctrl.vec_reg_wd = 1'b1;
                o_is_vec          = 1'b1;
            end
            OP_LDV: begin
                o_ctrl.vec_reg_w = 1'b1;
                o_ctrl.r_mem     = 1'b1;
                o_is_mem         = 1'b1;
            end
            OP_SETFV: begin
                o_ctrl.vec_reg_w   = 1'b1;
                o_ctrl.vec_reg_wfp = 1'b1;
                o_is_vec           = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : vsc_decode
`default_nettype wire

// File: rtl/vector_sequencer_cu.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sequencer_cu
//  Description : Control unit sequencing scalar instructions in one cycle and
//                vector instructions over VLEN/LANES beats, with a registered
//                compare flag for conditional branches.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_sequencer_cu
    import vsc_pkg::*;
#(
    parameter int ARQ   = 32,
    parameter int VLEN  = 16,
    parameter int LANES = 4,
    localparam int BEATS = (LANES > 0) ? VLEN / LANES : 1,
    localparam int BW    = (BEATS > 2) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [3:0]    opcode,
    output logic          instr_ready,
    input  logic          zero,
    input  logic          mem_ready,
    output logic          mux_pc,
    output logic          pc_en,
    output logic          sca_reg_w,
    output logic          vec_reg_w,
    output logic          sca_mux_exe,
    output logic          sca_alu_op,
    output logic          vec_alu_op,
    output logic          w_mem,
    output logic          r_mem,
    output logic          sca_reg_wd,
    output logic          vec_reg_wd,
    output logic          vec_reg_wfp,
    output logic [BW-1:0] beat_idx,
    output logic          busy,
    output logic          flag_zero,
    output logic          illegal
);

    localparam logic [BW-1:0] c_last_beat = BW'(BEATS - 1);

    // Reject geometries that do not split into whole beats.
    if (ARQ < 1 || LANES < 1 || VLEN < LANES || (VLEN % LANES) != 0) begin : g_param_check
        $error("vector_sequencer_cu: VLEN must be a positive multiple of LANES and ARQ positive");
    end

    state_e        r_state;
    state_e        w_next_state;
    logic [3:0]    r_op;
    logic [BW-1:0] r_beat;
    logic          r_flag_zero;
    logic [3:0]    w_dec_op;
    ctrl_t         w_dec_ctrl;
    ctrl_t         w_ctrl;
    logic          w_is_vec;
    logic          w_is_mem;
    logic          w_dec_illegal;
    logic          w_last;

    // Idle decodes the live opcode; vector states replay the latched one.
    assign w_dec_op = (r_state == S_IDLE) ? opcode : r_op;
    assign w_last   = (r_beat == c_last_beat);

    vsc_decode u_decode (
        .i_opcode    (w_dec_op),
        .i_flag_zero (r_flag_zero),
        .o_ctrl      (w_dec_ctrl),
        .o_is_vec    (w_is_vec),
        .o_is_mem    (w_is_mem),
        .o_illegal   (w_dec_illegal)
    );

    // Next-state and output logic; reset low forces every output quiet.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = c_ctrl_none;
        pc_en        = 1'b0;
        illegal      = 1'b0;
        instr_ready  = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (w_is_vec) begin
                        w_next_state = S_VEC;
                    end else if (w_is_mem) begin
                        w_next_state = S_MEM;
                    end else begin
                        w_ctrl  = w_dec_ctrl;
                        pc_en   = 1'b1;
                        illegal = w_dec_illegal;
                    end
                end
            end
            S_VEC: begin
                busy   = 1'b1;
                w_ctrl = w_dec_ctrl;
                if (w_last) begin
                    pc_en        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_MEM: begin
                busy   = 1'b1;
                w_ctrl = w_dec_ctrl;
                if (mem_ready && w_last) begin
                    pc_en        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (!rst_n) begin
            w_ctrl      = c_ctrl_none;
            pc_en       = 1'b0;
            illegal     = 1'b0;
            instr_ready = 1'b0;
            busy        = 1'b0;
        end
    end

    // State, latched opcode, beat counter and compare flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NOP;
            r_beat      <= '0;
            r_flag_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (w_is_vec || w_is_mem) begin
                            r_op   <= opcode;
                            r_beat <= '0;
                        end
                        if (opcode == OP_CMPEQ) begin
                            r_flag_zero <= zero;
                        end
                    end
                end
                S_VEC: r_beat <= w_last ? '0 : r_beat + BW'(1);
                S_MEM: begin
                    if (mem_ready) begin
                        r_beat <= w_last ? '0 : r_beat + BW'(1);
                    end
                end
                default: r_beat <= '0;
            endcase
        end
    end

    assign mux_pc      = w_ctrl.mux_pc;
    assign sca_reg_w   = w_ctrl.sca_reg_w;
    assign vec_reg_w   = w_ctrl.vec_reg_w;
    assign sca_mux_exe = w_ctrl.sca_mux_exe;
    assign sca_alu_op  = w_ctrl.sca_alu_op;
    assign vec_alu_op  = w_ctrl.vec_alu_op;
    assign w_mem       = w_ctrl.w_mem;
    assign r_mem       = w_ctrl.r_mem;
    assign sca_reg_wd  = w_ctrl.sca_reg_wd;
    assign vec_reg_wd  = w_ctrl.vec_reg_wd;
    assign vec_reg_wfp = w_ctrl.vec_reg_wfp;
    assign beat_idx    = r_beat;
    assign flag_zero   = r_flag_zero;

endmodule : vector_sequencer_cu
`default_nettype wire

// File: tb/tb_vector_sequencer_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_sequencer_cu
//  Description : Directed self-checking bench for vector_sequencer_cu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sequencer_cu;

    // Control bundle expectations, bit order:
    // {mux_pc, sca_reg_w, vec_reg_w, sca_mux_exe, sca_alu_op, vec_alu_op,
    //  w_mem, r_mem, sca_reg_wd, vec_reg_wd, vec_reg_wfp}
    localparam logic [10:0] c_none  = 11'b000_0000_0000;
    localparam logic [10:0] c_sum   = 11'b010_0000_0100;
    localparam logic [10:0] c_sumi  = 11'b010_1000_0000;
    localparam logic [10:0] c_subi  = 11'b010_1100_0000;
    localparam logic [10:0] c_seti  = 11'b010_0000_0000;
    localparam logic [10:0] c_j     = 11'b100_0000_0000;
    localparam logic [10:0] c_mulfv = 11'b001_0010_0010;
    localparam logic [10:0] c_ldv   = 11'b001_0000_1000;
    localparam logic [10:0] c_sumfv = 11'b000_0011_0000;
    localparam logic [10:0] c_setfv = 11'b001_0000_0001;

    int checks   = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       instr_ready, mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe;
    logic       sca_alu_op, vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd;
    logic       vec_reg_wfp, busy, flag_zero, illegal;
    logic [1:0] beat_idx;
    logic [10:0] ctrl;

    // Second instance with a single beat per vector.
    logic       s_valid;
    logic [3:0] s_opcode;
    logic       s_ready, s_mux_pc, s_pc_en, s_sca_reg_w, s_vec_reg_w, s_sca_mux_exe;
    logic       s_sca_alu_op, s_vec_alu_op, s_w_mem, s_r_mem, s_sca_reg_wd;
    logic       s_vec_reg_wd, s_vec_reg_wfp, s_busy, s_flag_zero, s_illegal;
    logic [0:0] s_beat_idx;

    always #5 clk = ~clk;

    assign ctrl = {mux_pc, sca_reg_w, vec_reg_w, sca_mux_exe, sca_alu_op, vec_alu_op,
                   w_mem, r_mem, sca_reg_wd, vec_reg_wd, vec_reg_wfp};

    vector_sequencer_cu u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .instr_ready(instr_ready), .zero(zero), .mem_ready(mem_ready),
        .mux_pc(mux_pc), .pc_en(pc_en), .sca_reg_w(sca_reg_w), .vec_reg_w(vec_reg_w),
        .sca_mux_exe(sca_mux_exe), .sca_alu_op(sca_alu_op), .vec_alu_op(vec_alu_op),
        .w_mem(w_mem), .r_mem(r_mem), .sca_reg_wd(sca_reg_wd), .vec_reg_wd(vec_reg_wd),
        .vec_reg_wfp(vec_reg_wfp), .beat_idx(beat_idx), .busy(busy),
        .flag_zero(flag_zero), .illegal(illegal)
    );

    vector_sequencer_cu #(.ARQ(32), .VLEN(4), .LANES(4)) u_dut_short (
        .clk(clk), .rst_n(rst_n), .instr_valid(s_valid), .opcode(s_opcode),
        .instr_ready(s_ready), .zero(zero), .mem_ready(mem_ready),
        .mux_pc(s_mux_pc), .pc_en(s_pc_en), .sca_reg_w(s_sca_reg_w), .vec_reg_w(s_vec_reg_w),
        .sca_mux_exe(s_sca_mux_exe), .sca_alu_op(s_sca_alu_op), .vec_alu_op(s_vec_alu_op),
        .w_mem(s_w_mem), .r_mem(s_r_mem), .sca_reg_wd(s_sca_reg_wd), .vec_reg_wd(s_vec_reg_wd),
        .vec_reg_wfp(s_vec_reg_wfp), .beat_idx(s_beat_idx), .busy(s_busy),
        .flag_zero(s_flag_zero), .illegal(s_illegal)
    );

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b0;
        s_valid = 1'b0; s_opcode = 4'b0111;
        #2;
        checks++;
        if (ctrl !== c_none || pc_en !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ctrl=%b pc_en=%b busy=%b illegal=%b, required all 0", ctrl, pc_en, busy, illegal);
        end
        checks++;
        if (beat_idx !== 2'd0 || flag_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: beat_idx=%0d flag_zero=%b, required 0 0", beat_idx, flag_zero);
        end
        @(negedge clk); instr_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: instr_ready=%b busy=%b, required 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_idle_quiet();
        @(negedge clk); instr_valid = 1'b0; opcode = 4'b0100; #2;
        checks++;
        if (ctrl !== c_none || pc_en !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: ctrl=%b pc_en=%b illegal=%b, required 0", ctrl, pc_en, illegal);
        end
    endtask

    task automatic test_scalar();
        logic [3:0]  ops [7];
        logic [10:0] exp [7];
        ops = '{4'b0100, 4'b0000, 4'b0010, 4'b1010, 4'b1000, 4'b0111, 4'b0110};
        exp = '{c_subi, c_sum, c_sumi, c_seti, c_j, c_none, c_none};
        zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); instr_valid = 1'b1; opcode = ops[i]; #2;
            checks++;
            if (ctrl !== exp[i] || pc_en !== 1'b1 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
                failures++;
                $display("FAIL scalar_op%b: ctrl=%b pc_en=%b illegal=%b ready=%b, required ctrl=%b pc_en=1 illegal=0 ready=1",
                         ops[i], ctrl, pc_en, illegal, instr_ready, exp[i]);
            end
        end
        @(negedge clk); instr_valid = 1'b0;
    endtask

    task automatic test_mulfv();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0011; #2;
        checks++;
        if (ctrl !== c_none || pc_en !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mulfv_accept: ctrl=%b pc_en=%b ready=%b busy=%b, required 0 0 1 0", ctrl, pc_en, instr_ready, busy);
        end
        for (int b = 0; b < 4; b++) begin
            // A competing scalar opcode must be ignored while busy.
            @(negedge clk); instr_valid = 1'b1; opcode = 4'b0000; #2;
            checks++;
            if (beat_idx !== 2'(b) || ctrl !== c_mulfv || busy !== 1'b1 || instr_ready !== 1'b0 ||
                pc_en !== (b == 3)) begin
                failures++;
                $display("FAIL mulfv_beat%0d: beat_idx=%0d ctrl=%b busy=%b ready=%b pc_en=%b, required beat=%0d ctrl=%b busy=1 ready=0 pc_en=%b",
                         b, beat_idx, ctrl, busy, instr_ready, pc_en, b, c_mulfv, (b == 3));
            end
        end
        @(negedge clk); instr_valid = 1'b0; #2;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || beat_idx !== 2'd0) begin
            failures++;
            $display("FAIL mulfv_done: ready=%b busy=%b beat_idx=%0d, required 1 0 0", instr_ready, busy, beat_idx);
        end
    endtask

    task automatic test_ldv_stall();
        logic       mr [6];
        logic [1:0] eb [6];
        mr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        eb = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0101; mem_ready = 1'b0; #2;
        checks++;
        if (instr_ready !== 1'b1 || ctrl !== c_none) begin
            failures++;
            $display("FAIL ldv_accept: ready=%b ctrl=%b, required 1 0", instr_ready, ctrl);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); instr_valid = 1'b0; mem_ready = mr[i]; #2;
            checks++;
            if (beat_idx !== eb[i] || ctrl !== c_ldv || busy !== 1'b1 || instr_ready !== 1'b0 ||
                pc_en !== (i == 5)) begin
                failures++;
                $display("FAIL ldv_cycle%0d: beat_idx=%0d ctrl=%b busy=%b ready=%b pc_en=%b, required beat=%0d ctrl=%b busy=1 ready=0 pc_en=%b",
                         i, beat_idx, ctrl, busy, instr_ready, pc_en, eb[i], c_ldv, (i == 5));
            end
        end
        @(negedge clk); mem_ready = 1'b0; #2;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ldv_done: ready=%b busy=%b, required 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_cmpeq_jeq();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0110; zero = 1'b1;
        @(negedge clk); opcode = 4'b1001; zero = 1'b0; #2;
        checks++;
        if (mux_pc !== 1'b1 || pc_en !== 1'b1 || flag_zero !== 1'b1) begin
            failures++;
            $display("FAIL jeq_taken: mux_pc=%b pc_en=%b flag_zero=%b, required 1 1 1", mux_pc, pc_en, flag_zero);
        end
        @(negedge clk); opcode = 4'b0110; zero = 1'b0;
        @(negedge clk); opcode = 4'b1001; zero = 1'b1; #2;
        checks++;
        if (mux_pc !== 1'b0 || pc_en !== 1'b1 || flag_zero !== 1'b0) begin
            failures++;
            $display("FAIL jeq_not_taken: mux_pc=%b pc_en=%b flag_zero=%b, required 0 1 0", mux_pc, pc_en, flag_zero);
        end
        // Flag holds across non-compare instructions.
        @(negedge clk); opcode = 4'b0110; zero = 1'b1;
        @(negedge clk); opcode = 4'b0111; zero = 1'b0;
        @(negedge clk); instr_valid = 1'b0; #2;
        checks++;
        if (flag_zero !== 1'b1) begin
            failures++;
            $display("FAIL flag_hold: flag_zero=%b, required 1", flag_zero);
        end
    endtask

    task automatic test_reset_abort();
        mem_ready = 1'b1;
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b0001;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #2;
        checks++;
        if (beat_idx !== 2'd2 || w_mem !== 1'b1 || ctrl !== c_sumfv) begin
            failures++;
            $display("FAIL sumfv_beat2: beat_idx=%0d ctrl=%b, required 2 %b", beat_idx, ctrl, c_sumfv);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (w_mem !== 1'b0 || pc_en !== 1'b0 || busy !== 1'b0 || beat_idx !== 2'd0) begin
            failures++;
            $display("FAIL abort_immediate: w_mem=%b pc_en=%b busy=%b beat_idx=%0d, required 0 0 0 0", w_mem, pc_en, busy, beat_idx);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1 || beat_idx !== 2'd0 || flag_zero !== 1'b0 || pc_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_release: ready=%b beat_idx=%0d flag_zero=%b pc_en=%b, required 1 0 0 0",
                     instr_ready, beat_idx, flag_zero, pc_en);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk); instr_valid = 1'b1; opcode = 4'b1111; #2;
        checks++;
        if (illegal !== 1'b1 || pc_en !== 1'b1 || ctrl !== c_none || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_1111: illegal=%b pc_en=%b ctrl=%b ready=%b, required 1 1 0 1", illegal, pc_en, ctrl, instr_ready);
        end
        @(negedge clk); opcode = 4'b1100; #2;
        checks++;
        if (illegal !== 1'b1 || pc_en !== 1'b1 || ctrl !== c_none) begin
            failures++;
            $display("FAIL illegal_1100: illegal=%b pc_en=%b ctrl=%b, required 1 1 0", illegal, pc_en, ctrl);
        end
        @(negedge clk); instr_valid = 1'b0; #2;
        checks++;
        if (illegal !== 1'b0 || pc_en !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse_end: illegal=%b pc_en=%b, required 0 0", illegal, pc_en);
        end
    endtask

    task automatic test_single_beat();
        @(negedge clk); s_valid = 1'b1; s_opcode = 4'b1011; #2;
        checks++;
        if (s_ready !== 1'b1 || s_vec_reg_w !== 1'b0 || s_pc_en !== 1'b0) begin
            failures++;
            $display("FAIL setfv1_accept: ready=%b vec_reg_w=%b pc_en=%b, required 1 0 0", s_ready, s_vec_reg_w, s_pc_en);
        end
        @(negedge clk); s_valid = 1'b0; #2;
        checks++;
        if (s_busy !== 1'b1 || s_pc_en !== 1'b1 || s_vec_reg_w !== 1'b1 || s_vec_reg_wfp !== 1'b1 ||
            s_beat_idx !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL setfv1_beat: busy=%b pc_en=%b vec_reg_w=%b wfp=%b beat=%0d ready=%b, required 1 1 1 1 0 0",
                     s_busy, s_pc_en, s_vec_reg_w, s_vec_reg_wfp, s_beat_idx, s_ready);
        end
        @(negedge clk); #2;
        checks++;
        if (s_ready !== 1'b1 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL setfv1_done: ready=%b busy=%b, required 1 0", s_ready, s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_idle_quiet();
        test_scalar();
        test_mulfv();
        test_ldv_stall();
        test_cmpeq_jeq();
        test_reset_abort();
        test_illegal();
        test_single_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vector_sequencer_cu
`default_nettype wire
